// File: rtl/axi4lite_mmio_pkg.sv
// Shared types and constants for the AXI4-Lite MMIO slave.
// Holds the write/read FSM state enums, the address-decode target enum,
// default MMIO addresses, and the out-of-bounds read pattern.
package axi4lite_mmio_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_EXEC,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_MEM,
    R_CAP,
    R_RESP
  } r_state_t;

  typedef enum logic [1:0] {
    TGT_SRAM,
    TGT_CONSOLE,
    TGT_PASS,
    TGT_OOB
  } target_t;

  localparam logic [31:0] OOB_RDATA        = 32'hDEAD_BEEF;
  localparam logic [31:0] DEF_CONSOLE_ADDR = 32'h1000_0000;
  localparam logic [31:0] DEF_PASS_ADDR    = 32'h2000_0000;
  localparam logic [31:0] DEF_PASS_MAGIC   = 32'd123456789;

  // SRAM window wins over the MMIO addresses; anything else is out of bounds.
  function automatic target_t decode_target(
    input logic [31:0] addr,
    input logic [32:0] mem_bytes,
    input logic [31:0] console_addr,
    input logic [31:0] pass_addr
  );
    if ({1'b0, addr} < mem_bytes)  return TGT_SRAM;
    else if (addr == console_addr) return TGT_CONSOLE;
    else if (addr == pass_addr)    return TGT_PASS;
    else                           return TGT_OOB;
  endfunction

endpackage

// File: rtl/mmio_console_fifo.sv
// Console byte FIFO with wrap-bit pointers and no bypass path.
// Ports: clk, resetn (async active-low); push/push_data/full on the write
// side; valid/ready/data on the read side (valid = not empty, data = head).
module mmio_console_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty;
  logic             do_push;
  logic             do_pop;

  // Same index with opposite wrap bits means the writer lapped the reader.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign valid   = !empty;
  assign do_push = push && !full;
  assign do_pop  = valid && ready;
  assign data    = mem[rd_ptr[IW-1:0]];

  // Pointer state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[IW-1:0]] <= push_data;
  end

endmodule

// File: rtl/axi4lite_mmio_slave.sv
// AXI4-Lite slave for the picorv32_axi master: on-chip SRAM, console byte
// stream, sticky tests-passed flag, and a sticky out-of-bounds flag.
// Ports: clk, resetn (async active-low); mem_axi_* AW/W/B/AR/R channels
// (no bresp/rresp, always OKAY); sram_* single-port SRAM interface with
// 1-cycle read latency; con_valid/con_ready/con_data console stream;
// tests_passed and err_oob sticky status outputs.
module axi4lite_mmio_slave
  import axi4lite_mmio_pkg::*;
#(
  parameter int unsigned MEM_WORDS    = 32768,
  parameter logic [31:0] CONSOLE_ADDR = DEF_CONSOLE_ADDR,
  parameter logic [31:0] PASS_ADDR    = DEF_PASS_ADDR,
  parameter logic [31:0] PASS_MAGIC   = DEF_PASS_MAGIC,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         mem_axi_awvalid,
  output logic                         mem_axi_awready,
  input  logic [31:0]                  mem_axi_awaddr,
  input  logic [2:0]                   mem_axi_awprot,
  input  logic                         mem_axi_wvalid,
  output logic                         mem_axi_wready,
  input  logic [31:0]                  mem_axi_wdata,
  input  logic [3:0]                   mem_axi_wstrb,
  output logic                         mem_axi_bvalid,
  input  logic                         mem_axi_bready,
  input  logic                         mem_axi_arvalid,
  output logic                         mem_axi_arready,
  input  logic [31:0]                  mem_axi_araddr,
  input  logic [2:0]                   mem_axi_arprot,
  output logic                         mem_axi_rvalid,
  input  logic                         mem_axi_rready,
  output logic [31:0]                  mem_axi_rdata,
  output logic                         sram_en,
  output logic [3:0]                   sram_we,
  output logic [$clog2(MEM_WORDS)-1:0] sram_addr,
  output logic [31:0]                  sram_wdata,
  input  logic [31:0]                  sram_rdata,
  output logic                         con_valid,
  input  logic                         con_ready,
  output logic [7:0]                   con_data,
  output logic                         tests_passed,
  output logic                         err_oob
);

  localparam int unsigned SRAM_AW   = $clog2(MEM_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

  // Write path state
  w_state_t           w_state, w_state_n;
  logic               aw_lat, aw_lat_n;
  logic               w_lat, w_lat_n;
  logic [SRAM_AW-1:0] waddr, waddr_n;
  logic [31:0]        wdata_q, wdata_n;
  logic [3:0]         wstrb_q, wstrb_n;
  target_t            w_tgt, w_tgt_n;

  // Read path state; rd_grant marks an SRAM cycle owned by the read
  r_state_t           r_state, r_state_n;
  logic [SRAM_AW-1:0] raddr, raddr_n;
  target_t            r_tgt, r_tgt_n;
  logic               rd_grant, rd_grant_n;

  // Registered output next-values
  logic               awready_n, wready_n, bvalid_n, arready_n, rvalid_n;
  logic [31:0]        rdata_n;
  logic               sram_en_n;
  logic [3:0]         sram_we_n;
  logic [SRAM_AW-1:0] sram_addr_n;
  logic [31:0]        sram_wdata_n;
  logic               tests_passed_n, err_oob_n;

  logic               aw_hs, w_hs, ar_hs, wr_claim;
  logic               con_push_c;
  logic               con_full;
  target_t            aw_tgt, ar_tgt;
  logic               unused_ok;

  assign aw_hs  = mem_axi_awvalid && mem_axi_awready;
  assign w_hs   = mem_axi_wvalid  && mem_axi_wready;
  assign ar_hs  = mem_axi_arvalid && mem_axi_arready;
  assign aw_tgt = decode_target(mem_axi_awaddr, MEM_BYTES, CONSOLE_ADDR, PASS_ADDR);
  assign ar_tgt = decode_target(mem_axi_araddr, MEM_BYTES, CONSOLE_ADDR, PASS_ADDR);
  assign unused_ok = ^{mem_axi_awprot, mem_axi_arprot};

  mmio_console_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_con_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (con_push_c),
    .push_data (wdata_q[7:0]),
    .full      (con_full),
    .valid     (con_valid),
    .ready     (con_ready),
    .data      (con_data)
  );

  // Next-state and registered-output logic for both FSMs and the SRAM port.
  always_comb begin
    w_state_n      = w_state;
    aw_lat_n       = aw_lat;
    w_lat_n        = w_lat;
    waddr_n        = waddr;
    wdata_n        = wdata_q;
    wstrb_n        = wstrb_q;
    w_tgt_n        = w_tgt;
    r_state_n      = r_state;
    raddr_n        = raddr;
    r_tgt_n        = r_tgt;
    rdata_n        = mem_axi_rdata;
    tests_passed_n = tests_passed;
    err_oob_n      = err_oob;
    con_push_c     = 1'b0;

    unique case (w_state)
      W_IDLE: begin
        if (aw_hs) begin
          aw_lat_n = 1'b1;
          waddr_n  = mem_axi_awaddr[2 +: SRAM_AW];
          w_tgt_n  = aw_tgt;
        end
        if (w_hs) begin
          w_lat_n = 1'b1;
          wdata_n = mem_axi_wdata;
          wstrb_n = mem_axi_wstrb;
        end
        if (aw_lat_n && w_lat_n) w_state_n = W_EXEC;
      end
      W_EXEC: begin
        w_state_n = W_RESP;
        case (w_tgt)
          TGT_CONSOLE: begin
            // Hold the write until the console FIFO has room.
            if (con_full) w_state_n  = W_EXEC;
            else          con_push_c = 1'b1;
          end
          TGT_PASS: if (wdata_q == PASS_MAGIC) tests_passed_n = 1'b1;
          TGT_OOB:  err_oob_n = 1'b1;
          default:  ;
        endcase
      end
      W_RESP: begin
        if (mem_axi_bvalid && mem_axi_bready) begin
          w_state_n = W_IDLE;
          aw_lat_n  = 1'b0;
          w_lat_n   = 1'b0;
        end
      end
      default: w_state_n = W_IDLE;
    endcase

    unique case (r_state)
      R_IDLE: begin
        if (ar_hs) begin
          raddr_n   = mem_axi_araddr[2 +: SRAM_AW];
          r_tgt_n   = ar_tgt;
          r_state_n = R_MEM;
        end
      end
      // An SRAM read waits here until it has actually owned a port cycle.
      R_MEM: if (r_tgt != TGT_SRAM || rd_grant) r_state_n = R_CAP;
      R_CAP: begin
        r_state_n = R_RESP;
        unique case (r_tgt)
          TGT_SRAM:    rdata_n = sram_rdata;
          TGT_CONSOLE: rdata_n = 32'h0;
          TGT_PASS:    rdata_n = {31'b0, tests_passed};
          TGT_OOB: begin
            rdata_n   = OOB_RDATA;
            err_oob_n = 1'b1;
          end
        endcase
      end
      R_RESP: if (mem_axi_rvalid && mem_axi_rready) r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase

    // SRAM port arbitration for next cycle: a write in W_EXEC has priority.
    wr_claim     = (w_state_n == W_EXEC) && (w_tgt_n == TGT_SRAM);
    rd_grant_n   = (r_state_n == R_MEM) && (r_tgt_n == TGT_SRAM) && !wr_claim;
    sram_en_n    = wr_claim || rd_grant_n;
    sram_we_n    = wr_claim ? wstrb_n : 4'b0000;
    sram_addr_n  = wr_claim ? waddr_n : raddr_n;
    sram_wdata_n = wdata_n;

    awready_n = (w_state_n == W_IDLE) && !aw_lat_n;
    wready_n  = (w_state_n == W_IDLE) && !w_lat_n;
    bvalid_n  = (w_state_n == W_RESP);
    arready_n = (r_state_n == R_IDLE);
    rvalid_n  = (r_state_n == R_RESP);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state         <= W_IDLE;
      aw_lat          <= 1'b0;
      w_lat           <= 1'b0;
      waddr           <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      w_tgt           <= TGT_SRAM;
      r_state         <= R_IDLE;
      raddr           <= '0;
      r_tgt           <= TGT_SRAM;
      rd_grant        <= 1'b0;
      mem_axi_awready <= 1'b0;
      mem_axi_wready  <= 1'b0;
      mem_axi_bvalid  <= 1'b0;
      mem_axi_arready <= 1'b0;
      mem_axi_rvalid  <= 1'b0;
      mem_axi_rdata   <= '0;
      sram_en         <= 1'b0;
      sram_we         <= '0;
      sram_addr       <= '0;
      sram_wdata      <= '0;
      tests_passed    <= 1'b0;
      err_oob         <= 1'b0;
    end else begin
      w_state         <= w_state_n;
      aw_lat          <= aw_lat_n;
      w_lat           <= w_lat_n;
      waddr           <= waddr_n;
      wdata_q         <= wdata_n;
      wstrb_q         <= wstrb_n;
      w_tgt           <= w_tgt_n;
      r_state         <= r_state_n;
      raddr           <= raddr_n;
      r_tgt           <= r_tgt_n;
      rd_grant        <= rd_grant_n;
      mem_axi_awready <= awready_n;
      mem_axi_wready  <= wready_n;
      mem_axi_bvalid  <= bvalid_n;
      mem_axi_arready <= arready_n;
      mem_axi_rvalid  <= rvalid_n;
      mem_axi_rdata   <= rdata_n;
      sram_en         <= sram_en_n;
      sram_we         <= sram_we_n;
      sram_addr       <= sram_addr_n;
      sram_wdata      <= sram_wdata_n;
      tests_passed    <= tests_passed_n;
      err_oob         <= err_oob_n;
    end
  end

endmodule

// File: tb/tb_axi4lite_mmio_slave.sv
// Self-checking bench for axi4lite_mmio_slave: SRAM model, scoreboard
// queues for read data and console bytes, latency and flag checks.
module tb_axi4lite_mmio_slave;
  import axi4lite_mmio_pkg::*;

  localparam int unsigned MEM_WORDS = 32768;
  localparam int unsigned SAW       = $clog2(MEM_WORDS);

  logic           clk = 1'b0;
  logic           resetn;
  logic           mem_axi_awvalid, mem_axi_awready;
  logic [31:0]    mem_axi_awaddr;
  logic [2:0]     mem_axi_awprot;
  logic           mem_axi_wvalid, mem_axi_wready;
  logic [31:0]    mem_axi_wdata;
  logic [3:0]     mem_axi_wstrb;
  logic           mem_axi_bvalid, mem_axi_bready;
  logic           mem_axi_arvalid, mem_axi_arready;
  logic [31:0]    mem_axi_araddr;
  logic [2:0]     mem_axi_arprot;
  logic           mem_axi_rvalid, mem_axi_rready;
  logic [31:0]    mem_axi_rdata;
  logic           sram_en;
  logic [3:0]     sram_we;
  logic [SAW-1:0] sram_addr;
  logic [31:0]    sram_wdata;
  logic [31:0]    sram_rdata;
  logic           con_valid, con_ready;
  logic [7:0]     con_data;
  logic           tests_passed, err_oob;

  int          checks = 0;
  int          failures = 0;
  int          wr_lat, rd_lat;
  bit          wr_busy = 1'b0;
  int          we_full_cycles = 0;
  int          b_count = 0;
  logic [31:0] rd_q[$];
  logic [7:0]  con_q[$];
  logic [31:0] mem [MEM_WORDS];

  axi4lite_mmio_slave dut (
    .clk             (clk),
    .resetn          (resetn),
    .mem_axi_awvalid (mem_axi_awvalid),
    .mem_axi_awready (mem_axi_awready),
    .mem_axi_awaddr  (mem_axi_awaddr),
    .mem_axi_awprot  (mem_axi_awprot),
    .mem_axi_wvalid  (mem_axi_wvalid),
    .mem_axi_wready  (mem_axi_wready),
    .mem_axi_wdata   (mem_axi_wdata),
    .mem_axi_wstrb   (mem_axi_wstrb),
    .mem_axi_bvalid  (mem_axi_bvalid),
    .mem_axi_bready  (mem_axi_bready),
    .mem_axi_arvalid (mem_axi_arvalid),
    .mem_axi_arready (mem_axi_arready),
    .mem_axi_araddr  (mem_axi_araddr),
    .mem_axi_arprot  (mem_axi_arprot),
    .mem_axi_rvalid  (mem_axi_rvalid),
    .mem_axi_rready  (mem_axi_rready),
    .mem_axi_rdata   (mem_axi_rdata),
    .sram_en         (sram_en),
    .sram_we         (sram_we),
    .sram_addr       (sram_addr),
    .sram_wdata      (sram_wdata),
    .sram_rdata      (sram_rdata),
    .con_valid       (con_valid),
    .con_ready       (con_ready),
    .con_data        (con_data),
    .tests_passed    (tests_passed),
    .err_oob         (err_oob)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // SRAM behavioural model: 1-cycle read latency, byte-enabled writes.
  initial begin
    for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = 32'h0;
  end
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we == 4'b0000) sram_rdata <= mem[sram_addr];
      else begin
        for (int b = 0; b < 4; b++)
          if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
    end
  end

  // Output monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (resetn) begin
      if (sram_en && sram_we == 4'b1111) we_full_cycles++;
      if (mem_axi_bvalid && mem_axi_bready) b_count++;
      if (mem_axi_rvalid && mem_axi_rready) begin
        if (rd_q.size() == 0) check_eq("rdata_unexpected", mem_axi_rdata, 32'h0BAD_0BAD);
        else check_eq("rdata", mem_axi_rdata, rd_q.pop_front());
      end
      if (con_valid && con_ready) begin
        if (con_q.size() == 0) check_eq("con_unexpected", 32'(con_data), 32'h0BAD_0BAD);
        else check_eq("con_data", 32'(con_data), 32'(con_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // AXI write; W is offered w_lead cycles before AW. wr_lat counts edges
  // from the later handshake to the edge that raises bvalid.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead);
    int cyc = 0;
    bit aw_done = 1'b0;
    bit w_done = 1'b0;
    bit hs_aw, hs_w;
    wr_busy = 1'b1;
    mem_axi_wvalid = 1'b1;
    mem_axi_wdata  = data;
    mem_axi_wstrb  = strb;
    if (w_lead == 0) begin
      mem_axi_awvalid = 1'b1;
      mem_axi_awaddr  = addr;
    end
    while (!(aw_done && w_done) && cyc < 200) begin
      @(negedge clk);
      hs_aw = mem_axi_awvalid && mem_axi_awready;
      hs_w  = mem_axi_wvalid && mem_axi_wready;
      tick();
      cyc++;
      if (hs_aw) begin aw_done = 1'b1; mem_axi_awvalid = 1'b0; end
      if (hs_w)  begin w_done = 1'b1;  mem_axi_wvalid = 1'b0;  end
      if (!aw_done && !mem_axi_awvalid && cyc >= w_lead) begin
        mem_axi_awvalid = 1'b1;
        mem_axi_awaddr  = addr;
      end
    end
    check_eq("aw_w_accept", 32'({aw_done, w_done}), 32'h3);
    wr_lat = 0;
    @(negedge clk);
    while (!mem_axi_bvalid && wr_lat < 200) begin
      @(negedge clk);
      wr_lat++;
    end
    check_eq("bvalid_seen", 32'(mem_axi_bvalid), 32'h1);
    tick();
    wr_busy = 1'b0;
  endtask

  // AXI read; the expected data goes on the scoreboard when AR is driven.
  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp);
    int cyc = 0;
    bit done = 1'b0;
    bit hs;
    rd_q.push_back(exp);
    mem_axi_arvalid = 1'b1;
    mem_axi_araddr  = addr;
    while (!done && cyc < 200) begin
      @(negedge clk);
      hs = mem_axi_arvalid && mem_axi_arready;
      tick();
      cyc++;
      if (hs) begin done = 1'b1; mem_axi_arvalid = 1'b0; end
    end
    check_eq("ar_accept", 32'(done), 32'h1);
    rd_lat = 0;
    @(negedge clk);
    while (!mem_axi_rvalid && rd_lat < 200) begin
      @(negedge clk);
      rd_lat++;
    end
    check_eq("rvalid_seen", 32'(mem_axi_rvalid), 32'h1);
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  b0, we0;
    bit  stall_b;
    resetn          = 1'b0;
    mem_axi_awvalid = 1'b0;
    mem_axi_awaddr  = '0;
    mem_axi_awprot  = '0;
    mem_axi_wvalid  = 1'b0;
    mem_axi_wdata   = '0;
    mem_axi_wstrb   = '0;
    mem_axi_bready  = 1'b1;
    mem_axi_arvalid = 1'b0;
    mem_axi_araddr  = '0;
    mem_axi_arprot  = '0;
    mem_axi_rready  = 1'b1;
    con_ready       = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", 32'({mem_axi_awready, mem_axi_wready, mem_axi_arready}), 32'h0);
    check_eq("rst_valid", 32'({mem_axi_bvalid, mem_axi_rvalid, con_valid}), 32'h0);
    check_eq("rst_rdata", mem_axi_rdata, 32'h0);
    check_eq("rst_sram", 32'({sram_en, sram_we}), 32'h0);
    check_eq("rst_flags", 32'({tests_passed, err_oob}), 32'h0);
    tick();
    resetn = 1'b1;
    repeat (2) tick();

    // SRAM full-word write then read
    we0 = we_full_cycles;
    axi_write(32'h0000_0100, 32'hA5A5_1234, 4'b1111, 0);
    check_eq("t1_b_latency", 32'(wr_lat), 32'd1);
    axi_read(32'h0000_0100, 32'hA5A5_1234);
    check_eq("t1_r_latency", 32'(rd_lat), 32'd2);
    check_eq("t1_we_cycles", 32'(we_full_cycles - we0), 32'd1);

    // Byte strobe with W leading AW by 3 cycles
    b0 = b_count;
    axi_write(32'h0000_0104, 32'hFFFF_FFFF, 4'b0010, 3);
    check_eq("t2_b_count", 32'(b_count - b0), 32'd1);
    axi_read(32'h0000_0104, 32'h0000_FF00);

    // Console backpressure: 16 fit, the 17th stalls
    con_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      con_q.push_back(8'(8'h41 + i));
      axi_write(DEF_CONSOLE_ADDR, 32'(8'h41 + i), 4'b0001, 0);
      check_eq("con_accept_latency", 32'(wr_lat), 32'd1);
    end
    con_q.push_back(8'h51);
    fork
      axi_write(DEF_CONSOLE_ADDR, 32'h0000_0051, 4'b0001, 0);
    join_none
    stall_b = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (mem_axi_bvalid) stall_b = 1'b1;
    end
    check_eq("con_stall_bvalid", 32'(stall_b), 32'h0);
    check_eq("con_full_valid", 32'(con_valid), 32'h1);
    tick();
    con_ready = 1'b1;
    for (int i = 0; i < 200 && wr_busy; i++) tick();
    check_eq("con_17th_done", 32'(wr_busy), 32'h0);
    for (int i = 0; i < 200 && con_q.size() != 0; i++) tick();
    check_eq("con_drained", 32'(con_q.size()), 32'h0);

    // Pass flag
    axi_write(DEF_PASS_ADDR, 32'd5, 4'b1111, 0);
    check_eq("pass_wrong_value", 32'(tests_passed), 32'h0);
    axi_write(DEF_PASS_ADDR, DEF_PASS_MAGIC, 4'b1111, 0);
    check_eq("pass_magic", 32'(tests_passed), 32'h1);
    axi_read(DEF_PASS_ADDR, 32'h0000_0001);

    // Out-of-bounds read
    check_eq("oob_before", 32'(err_oob), 32'h0);
    axi_read(32'h0002_0000, 32'hDEAD_BEEF);
    check_eq("oob_after", 32'(err_oob), 32'h1);

    // Simultaneous SRAM write and read to different words
    axi_write(32'h0000_0204, 32'h1234_5678, 4'b1111, 0);
    fork
      axi_write(32'h0000_0200, 32'hCAFE_0001, 4'b1111, 0);
      axi_read(32'h0000_0204, 32'h1234_5678);
    join
    check_eq("contend_b_latency", 32'(wr_lat), 32'd1);
    check_eq("contend_r_latency", 32'(rd_lat), 32'd3);
    axi_read(32'h0000_0200, 32'hCAFE_0001);

    // Reset asserted while a read sits in R_CAP
    con_ready = 1'b0;
    axi_write(DEF_CONSOLE_ADDR, 32'h0000_0058, 4'b0001, 0);
    axi_write(DEF_CONSOLE_ADDR, 32'h0000_0059, 4'b0001, 0);
    check_eq("rr_fifo_loaded", 32'(con_valid), 32'h1);
    mem_axi_arvalid = 1'b1;
    mem_axi_araddr  = 32'h0000_0100;
    @(negedge clk);
    check_eq("rr_arready", 32'(mem_axi_arready), 32'h1);
    tick();
    mem_axi_arvalid = 1'b0;
    tick();
    resetn = 1'b0;
    #1;
    check_eq("rr_rvalid", 32'(mem_axi_rvalid), 32'h0);
    check_eq("rr_arready_rst", 32'(mem_axi_arready), 32'h0);
    check_eq("rr_fifo_empty", 32'(con_valid), 32'h0);
    check_eq("rr_flags", 32'({tests_passed, err_oob}), 32'h0);
    tick();
    resetn = 1'b1;
    repeat (2) tick();
    con_ready = 1'b1;
    axi_read(32'h0000_0100, 32'hA5A5_1234);
    check_eq("rr_fresh_latency", 32'(rd_lat), 32'd2);
    repeat (3) tick();

    check_eq("rd_q_empty", 32'(rd_q.size()), 32'h0);
    check_eq("con_q_empty", 32'(con_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4lite_mmio_slave.md
Name: axi4lite_mmio_slave

Overview:
Synthesizable AXI4-Lite slave that sits directly downstream of the picorv32_axi master port, replacing the behavioural memory model for FPGA/emulation builds. It decodes each access to one of three targets:
- single-port on-chip SRAM (1-cycle read latency)
- a console byte stream backed by a small FIFO
- a sticky "tests passed" flag
Out-of-bounds accesses are flagged instead of halting simulation.

Parameters:
MEM_WORDS, 32768, SRAM depth in 32-bit words (128 KiB)
CONSOLE_ADDR, 32'h1000_0000, console write address
PASS_ADDR, 32'h2000_0000, test-pass write address
PASS_MAGIC, 32'd123456789, value that sets tests_passed
FIFO_DEPTH, 16, console FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
mem_axi_awvalid/awready  in/out  1/1  write-address handshake
mem_axi_awaddr  in  32  write address
mem_axi_awprot  in  3  ignored
mem_axi_wvalid/wready  in/out  1/1  write-data handshake
mem_axi_wdata  in  32  write data
mem_axi_wstrb  in  4  byte enables
mem_axi_bvalid/bready  out/in  1/1  write response (always OKAY, no bresp port)
mem_axi_arvalid/arready  in/out  1/1  read-address handshake
mem_axi_araddr  in  32  read address
mem_axi_arprot  in  3  ignored
mem_axi_rvalid/rready  out/in  1/1  read response
mem_axi_rdata  out  32  read data
sram_en  out  1  SRAM access strobe
sram_we  out  4  SRAM byte write enables
sram_addr  out  $clog2(MEM_WORDS)  word index
sram_wdata  out  32  SRAM write data
sram_rdata  in  32  SRAM read data, valid the cycle after sram_en with sram_we==0
con_valid/con_ready  out/in  1/1  console byte stream
con_data  out  8  console byte
tests_passed  out  1  sticky pass flag
err_oob  out  1  sticky out-of-bounds flag

Behaviour:
- Reset (async, resetn=0): all of the following go to 0, FSMs go to IDLE, FIFO is emptied, and any in-flight transaction is dropped:
  - awready, wready, bvalid, arready, rvalid, rdata
  - sram_en, sram_we
  - con_valid, tests_passed, err_oob
- Address decode: SRAM if addr < MEM_WORDS*4, with sram_addr = addr[2+:$clog2(MEM_WORDS)] and addr[1:0] ignored. Otherwise CONSOLE_ADDR, then PASS_ADDR, then out-of-bounds (OOB).
- Write FSM states: W_IDLE, W_EXEC, W_RESP.
  - W_IDLE:
    - awready=1 while AW not latched; wready=1 while W not latched.
    - AW and W are accepted independently, in either order or in the same cycle.
    - Go to W_EXEC once both are latched.
  - W_EXEC, by target:
    - SRAM: sram_en=1, sram_we=wstrb.
    - CONSOLE: push wdata[7:0]. If the FIFO is full, stay in W_EXEC (stall) until not full.
    - PASS: if wdata==PASS_MAGIC, set tests_passed; any other value leaves it unchanged.
    - OOB: set err_oob; the write is dropped.
    - wstrb==0 is a no-op for SRAM but still returns a response.
    - Next state is W_RESP.
  - W_RESP: bvalid=1 until bvalid&&bready, then W_IDLE.
  - Latency: bvalid rises 1 cycle after the later of the AW/W handshakes (FIFO not full).
- Read FSM states: R_IDLE, R_MEM, R_CAP, R_RESP.
  - R_IDLE: arready=1. A handshake latches araddr and moves to R_MEM.
  - R_MEM: drive sram_en=1, sram_we=0 (SRAM target only), then R_CAP.
  - R_CAP: capture rdata from the target:
    - SRAM: sram_rdata
    - CONSOLE: 0
    - PASS: {31'b0, tests_passed}
    - OOB: 32'hDEAD_BEEF, and set err_oob
    - Set rvalid=1 and go to R_RESP.
  - R_RESP: hold rdata stable until rready, then R_IDLE.
  - Latency: rvalid high 2 cycles after the AR handshake when uncontended.
- SRAM contention: if W_EXEC (SRAM target) and R_MEM coincide, the write wins and R_MEM stays one extra cycle. Reads are never starved, because the write FSM cannot re-enter W_EXEC without passing through W_RESP.
- Outstanding transactions: at most one read and one write; the read and write paths run concurrently.
- Console FIFO:
  - Pointers are $clog2(FIFO_DEPTH)+1 bits with a wrap bit. full = MSBs differ and the rest are equal; empty = pointers equal.
  - Pop on con_valid&&con_ready; con_data is the head entry; con_valid = !empty.
  - No bypass: a push into an empty FIFO raises con_valid the next cycle.
  - A push when full is not performed (stall). Simultaneous push and pop when not full are both performed.
  - Pointers wrap modulo FIFO_DEPTH.
- tests_passed and err_oob are cleared only by reset.

Decomposition:
- Package axi4lite_mmio_pkg holds:
  - write-state and read-state enums
  - target-select enum (SRAM/CONSOLE/PASS/OOB)
  - OOB_RDATA = 32'hDEAD_BEEF
  - default CONSOLE_ADDR, PASS_ADDR, PASS_MAGIC
- One sub-module: mmio_console_fifo (parameter DEPTH, width 8; push/full on the write side, valid/ready/data on the read side).

Test Plan:
- SRAM write then read: AW and W together, addr 0x100, data 0xA5A5_1234, wstrb 4'b1111; then AR to 0x100 → bvalid 1 cycle after the handshake, rdata 0xA5A5_1234, rvalid 2 cycles after AR; sram_we==4'b1111 for exactly 1 cycle.
- Byte strobe with W before AW: W (0xFFFF_FFFF, wstrb 4'b0010) 3 cycles before AW to 0x104, word initially 0 → readback 0x0000_FF00, single bvalid.
- Console backpressure: con_ready=0, 17 writes 'A'..'Q' to CONSOLE_ADDR → 16 accepted; the 17th stalls with bvalid low. Raise con_ready → bytes appear in order 'A'..'Q' and the 17th bvalid follows.
- Pass flag: write 5 to PASS_ADDR → tests_passed=0; write 123456789 → tests_passed=1; read PASS_ADDR → rdata 1.
- OOB and contention: read 0x0002_0000 → rdata 0xDEAD_BEEF and err_oob=1. An SRAM write and read in the same cycle to different words → write first, read rvalid 1 cycle later than uncontended.
- Reset mid-read: resetn low in R_CAP → rvalid, arready, FIFO and flags all 0 immediately. After release, a fresh read completes normally.
